// File: rtl/rv32i_data_memory.sv
// Word-organised data memory answering RV32I byte/half/word loads and stores
// over a ready/valid handshake; loads take one cycle, stores commit on accept.
module rv32i_data_memory #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        memload_flag,
    input  logic        memstore_flag,
    input  logic [31:0] memory_address,
    input  logic [31:0] to_memory,
    input  logic [2:0]  access_size,
    output logic        mem_ready,
    output logic [31:0] from_memory,
    output logic        resp_valid,
    output logic        mem_fault
);

    typedef enum logic {IDLE, LOAD_RESP} state_t;

    state_t                 state;
    logic [31:0]            mem [0:(1 << ADDR_WIDTH) - 1];
    logic [31:0]            off;
    logic [ADDR_WIDTH-1:0]  index;
    logic [1:0]             lane;
    logic                   out_of_range;
    logic                   misaligned;
    logic                   size_bad;
    logic                   fault;
    logic                   accept;
    logic                   do_write;
    logic                   do_read;
    logic [3:0]             be;
    logic [31:0]            wdata;
    logic [31:0]            rd_word;
    logic [1:0]             lat_lane;
    logic [2:0]             lat_size;
    logic                   load_ok;
    logic [31:0]            shifted;

    // Modular subtraction makes addresses below BASE_ADDR wrap high and fault as out of range.
    assign off          = memory_address - BASE_ADDR;
    assign index        = off[ADDR_WIDTH+1:2];
    assign lane         = off[1:0];
    assign out_of_range = (off >> (ADDR_WIDTH + 2)) != 32'd0;
    assign mem_ready    = (state == IDLE);
    assign accept       = mem_ready && (memload_flag || memstore_flag);

    always_comb begin
        misaligned = 1'b0;
        case (access_size[1:0])
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off[1:0] != 2'd0);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        if (memload_flag)
            size_bad = (access_size == 3'd3) || (access_size == 3'd6) || (access_size == 3'd7);
        else
            size_bad = (access_size > 3'd2);
    end

    assign fault    = (memload_flag && memstore_flag) || out_of_range || misaligned || size_bad;
    assign do_write = accept && memstore_flag && !fault && sys_reset;
    assign do_read  = accept && memload_flag && !fault;

    // Store data is replicated across lanes so the byte enables alone pick the destination.
    always_comb begin
        be    = 4'b0000;
        wdata = to_memory;
        case (access_size[1:0])
            2'd0: begin
                be    = 4'b0001 << lane;
                wdata = {4{to_memory[7:0]}};
            end
            2'd1: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{to_memory[15:0]}};
            end
            2'd2: begin
                be    = 4'b1111;
                wdata = to_memory;
            end
            default: begin
                be    = 4'b0000;
                wdata = to_memory;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (do_read) begin
            rd_word  <= mem[index];
            lat_lane <= lane;
            lat_size <= access_size;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            mem_fault  <= 1'b0;
            load_ok    <= 1'b0;
        end else begin
            resp_valid <= accept;
            mem_fault  <= accept && fault;
            load_ok    <= do_read;
            state      <= (accept && memload_flag) ? LOAD_RESP : IDLE;
        end
    end

    assign shifted = rd_word >> {lat_lane, 3'b000};

    always_comb begin
        from_memory = 32'd0;
        if (load_ok) begin
            case (lat_size)
                3'd0:    from_memory = {{24{shifted[7]}}, shifted[7:0]};
                3'd4:    from_memory = {24'd0, shifted[7:0]};
                3'd1:    from_memory = {{16{shifted[15]}}, shifted[15:0]};
                3'd5:    from_memory = {16'd0, shifted[15:0]};
                default: from_memory = shifted;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_data_memory.sv
// Bench for rv32i_data_memory: byte-array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rv32i_data_memory;

    localparam int          AW        = 10;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          MEM_BYTES = 4 << AW;

    logic        sys_clk = 1'b0;
    logic        sys_reset = 1'b0;
    logic        memload_flag = 1'b0;
    logic        memstore_flag = 1'b0;
    logic [31:0] memory_address = 32'd0;
    logic [31:0] to_memory = 32'd0;
    logic [2:0]  access_size = 3'd0;
    logic        mem_ready;
    logic [31:0] from_memory;
    logic        resp_valid;
    logic        mem_fault;

    rv32i_data_memory #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .memload_flag   (memload_flag),
        .memstore_flag  (memstore_flag),
        .memory_address (memory_address),
        .to_memory      (to_memory),
        .access_size    (access_size),
        .mem_ready      (mem_ready),
        .from_memory    (from_memory),
        .resp_valid     (resp_valid),
        .mem_fault      (mem_fault)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic        busy = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_fault = 1'b0;
    logic [31:0] exp_data = 32'd0;
    logic        exp_ready = 1'b1;
    logic        chk_en = 1'b0;

    logic        cap_valid;
    logic        cap_fault;
    logic [31:0] cap_data;
    logic        cap_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory is a flat little-endian byte array.
    initial begin : model
        logic [31:0] off;
        logic [31:0] val;
        int          nb;
        int          idx;
        logic        bad;
        logic        ld;
        logic        st;
        forever begin
            @(posedge sys_clk);
            ld = memload_flag;
            st = memstore_flag;
            if (!sys_reset) begin
                exp_valid = 1'b0; exp_fault = 1'b0; exp_data = 32'd0; busy = 1'b0;
            end else if (!busy && (ld || st)) begin
                off = memory_address - BASE;
                case (access_size)
                    3'd0, 3'd4: nb = 1;
                    3'd1, 3'd5: nb = 2;
                    3'd2:       nb = 4;
                    default:    nb = 0;
                endcase
                bad = (ld && st) || (off >= MEM_BYTES);
                if (ld) bad = bad || !(access_size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                else    bad = bad || !(access_size inside {3'd0, 3'd1, 3'd2});
                if (nb > 1) bad = bad || ((off % nb) != 0);
                val = 32'd0;
                if (!bad) begin
                    idx = int'(off);
                    for (int i = 0; i < nb; i++) begin
                        if (st) ref_mem[idx + i] = to_memory[8*i +: 8];
                        else    val = val | ({24'd0, ref_mem[idx + i]} << (8 * i));
                    end
                    if (ld && access_size == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
                    if (ld && access_size == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
                end
                exp_valid = 1'b1;
                exp_fault = bad;
                exp_data  = (ld && !bad) ? val : 32'd0;
                busy      = ld;
            end else begin
                exp_valid = 1'b0; exp_fault = 1'b0; exp_data = 32'd0; busy = 1'b0;
            end
            exp_ready = !busy;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("cyc resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
            check("cyc mem_fault", {31'd0, mem_fault}, {31'd0, exp_fault});
            check("cyc from_memory", from_memory, exp_data);
            check("cyc mem_ready", {31'd0, mem_ready}, {31'd0, exp_ready});
        end
    end

    // Called at a falling edge; returns at the falling edge of the response cycle.
    task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] sz);
        int n = 0;
        memload_flag = ld; memstore_flag = st; memory_address = a; to_memory = d; access_size = sz;
        while (!mem_ready && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        if (!mem_ready) check("accept timeout", 32'd0, 32'd1);
        @(negedge sys_clk);
        cap_valid = resp_valid; cap_fault = mem_fault; cap_data = from_memory; cap_ready = mem_ready;
        memload_flag = 1'b0; memstore_flag = 1'b0;
    endtask

    task automatic load_expect(input string name, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] exp);
        issue(1'b1, 1'b0, a, 32'd0, sz);
        check({name, " valid"}, {31'd0, cap_valid}, 32'd1);
        check({name, " fault"}, {31'd0, cap_fault}, 32'd0);
        check({name, " data"}, cap_data, exp);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < (1 << AW); i++) begin
            w = (i == 0) ? 32'h0BAD_C0DE : $urandom;
            dut.mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end

        repeat (3) @(negedge sys_clk);
        sys_reset = 1'b1;
        chk_en = 1'b1;
        check("reset ready", {31'd0, mem_ready}, 32'd1);
        check("reset valid", {31'd0, resp_valid}, 32'd0);
        check("reset fault", {31'd0, mem_fault}, 32'd0);
        check("reset data", from_memory, 32'd0);

        issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2);
        check("sw valid", {31'd0, cap_valid}, 32'd1);
        check("sw fault", {31'd0, cap_fault}, 32'd0);
        load_expect("lw 0x10", 32'h10, 3'd2, 32'hDEAD_BEEF);
        check("lw busy", {31'd0, cap_ready}, 32'd0);

        issue(1'b0, 1'b1, 32'h13, 32'h0000_0080, 3'd0);
        load_expect("lb 0x13", 32'h13, 3'd0, 32'hFFFF_FF80);
        load_expect("lbu 0x13", 32'h13, 3'd4, 32'h0000_0080);
        load_expect("lw after sb", 32'h10, 3'd2, 32'h80AD_BEEF);

        issue(1'b0, 1'b1, 32'h12, 32'h0000_1234, 3'd1);
        load_expect("lw after sh", 32'h10, 3'd2, 32'h1234_BEEF);
        issue(1'b1, 1'b0, 32'h11, 32'd0, 3'd1);
        check("lh misalign fault", {31'd0, cap_fault}, 32'd1);
        check("lh misalign data", cap_data, 32'd0);

        issue(1'b0, 1'b1, 32'h1000, 32'hCAFE_F00D, 3'd2);
        check("sw oor fault", {31'd0, cap_fault}, 32'd1);
        load_expect("lw 0x0 no alias", 32'h0, 3'd2, 32'h0BAD_C0DE);
        issue(1'b1, 1'b0, 32'h1000, 32'd0, 3'd2);
        check("lw oor fault", {31'd0, cap_fault}, 32'd1);

        @(negedge sys_clk);
        memstore_flag = 1'b1; access_size = 3'd2;
        memory_address = 32'h20; to_memory = 32'h1111_AAAA;
        check("b2b sw0 ready", {31'd0, mem_ready}, 32'd1);
        @(negedge sys_clk);
        check("b2b sw1 ready", {31'd0, mem_ready}, 32'd1);
        check("b2b sw0 valid", {31'd0, resp_valid}, 32'd1);
        memory_address = 32'h24; to_memory = 32'h2222_BBBB;
        @(negedge sys_clk);
        check("b2b sw2 ready", {31'd0, mem_ready}, 32'd1);
        check("b2b sw1 valid", {31'd0, resp_valid}, 32'd1);
        memory_address = 32'h28; to_memory = 32'h3333_CCCC;
        @(negedge sys_clk);
        check("b2b sw2 valid", {31'd0, resp_valid}, 32'd1);
        memstore_flag = 1'b0;
        memload_flag = 1'b1; memory_address = 32'h20;
        @(negedge sys_clk);
        check("held lw0 data", from_memory, 32'h1111_AAAA);
        check("held lw stall", {31'd0, mem_ready}, 32'd0);
        memory_address = 32'h28;
        @(negedge sys_clk);
        check("held lw ready", {31'd0, mem_ready}, 32'd1);
        check("held lw gap valid", {31'd0, resp_valid}, 32'd0);
        @(negedge sys_clk);
        check("held lw1 valid", {31'd0, resp_valid}, 32'd1);
        check("held lw1 data", from_memory, 32'h3333_CCCC);
        memload_flag = 1'b0;

        issue(1'b1, 1'b1, 32'h20, 32'd0, 3'd2);
        check("both flags fault", {31'd0, cap_fault}, 32'd1);
        check("both flags data", cap_data, 32'd0);

        issue(1'b1, 1'b0, 32'h24, 32'd0, 3'd2);
        sys_reset = 1'b0;
        @(negedge sys_clk);
        check("rst mid valid", {31'd0, resp_valid}, 32'd0);
        check("rst mid data", from_memory, 32'd0);
        check("rst mid ready", {31'd0, mem_ready}, 32'd1);
        sys_reset = 1'b1;
        load_expect("lw after rst", 32'h24, 3'd2, 32'h2222_BBBB);

        for (int k = 0; k < 400; k++) begin
            int          r;
            logic        ld;
            logic        st;
            logic [31:0] a;
            logic [2:0]  sz;
            r  = $urandom_range(0, 99);
            ld = (r < 45) || (r >= 90);
            st = (r >= 45);
            if (r == 99) begin
                sys_reset = 1'b0;
                @(negedge sys_clk);
                sys_reset = 1'b1;
            end
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = MEM_BYTES - 8 + $urandom_range(0, 15);
                default: a = $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 4) == 0) sz = 3'($urandom_range(0, 7));
            else if (ld)                   sz = 3'($urandom_range(0, 4)) + ((r & 1) != 0 ? 3'd0 : 3'd0);
            else                           sz = 3'($urandom_range(0, 2));
            if (ld && sz == 3'd3) sz = 3'd5;
            issue(ld, st, a, $urandom, sz);
        end

        @(negedge sys_clk);
        @(negedge sys_clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
